k580vt57: RTL and testbench



---
 rtl/k580vt57_pkg.sv | 36 +++
 rtl/k580vt57_if.sv | 33 +++
 rtl/k580vt57_prio.sv | 47 ++++
 rtl/k580vt57.sv | 198 +++++++++++++++++++
 tb/tb_k580vt57.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/k580vt57_pkg.sv
// Purpose : shared encodings for the k580vt57 DMA controller (FSM states, transfer types, register map, mode/status bits).
// Latency : n/a (declarations only).
// Backpressure : n/a.
package k580vt57_pkg;

   // Transfer sequencer states; a state only advances on a ce_dma cycle.
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_S0   = 3'd1,
      ST_S1   = 3'd2,
      ST_S2   = 3'd3,
      ST_S3   = 3'd4
   } state_t;

   // Transfer type held in count[15:14]; 2'b11 falls through to verify.
   localparam logic [1:0] TYP_VERIFY = 2'b00;
   localparam logic [1:0] TYP_WRITE  = 2'b01;  // io_rd + mem_wr
   localparam logic [1:0] TYP_READ   = 2'b10;  // mem_rd + io_wr

   // CPU register map: iaddr[3]=0 selects channel registers, 8 is mode/status.
   localparam logic [3:0] REG_MODE = 4'd8;

   // Mode register bit positions (bit 5 is ignored).
   localparam int MODE_ROT  = 4;
   localparam int MODE_STOP = 6;
   localparam int MODE_AUTO = 7;

   // Status register: [3:0] TC flags, [4] update flag.
   localparam int STAT_UPD = 4;

   // Replace the low or high byte of a 16-bit channel register.
   function automatic logic [15:0] put_byte(input logic [15:0] v, input logic hi, input logic [7:0] b);
      return hi ? {b, v[7:0]} : {v[15:8], b};
   endfunction

endpackage

// File: rtl/k580vt57_if.sv
// Purpose : CPU-bus and DMA-bus signal bundle of the k580vt57.
// Latency : n/a (wiring only).
// Backpressure : n/a; drq/hlda are the request/acknowledge pair, dack/hrq the answers.
// Ports : iaddr/idata/odata/iwe_n/ird_n = CPU register port; drq/dack/hrq/hlda = DMA handshakes;
//         oaddr/mem_rd/mem_wr/io_rd/io_wr/tc/mark = transfer bus.
interface k580vt57_if #(parameter int CH = 4);
   logic [3:0]    iaddr;
   logic [7:0]    idata;
   logic [7:0]    odata;
   logic          iwe_n;
   logic          ird_n;
   logic [CH-1:0] drq;
   logic [CH-1:0] dack;
   logic          hrq;
   logic          hlda;
   logic [15:0]   oaddr;
   logic          mem_rd;
   logic          mem_wr;
   logic          io_rd;
   logic          io_wr;
   logic          tc;
   logic          mark;

   // master = CPU/peripheral side, slave = the controller itself.
   modport master (
      output iaddr, idata, iwe_n, ird_n, drq, hlda,
      input  odata, dack, hrq, oaddr, mem_rd, mem_wr, io_rd, io_wr, tc, mark
   );
   modport slave (
      input  iaddr, idata, iwe_n, ird_n, drq, hlda,
      output odata, dack, hrq, oaddr, mem_rd, mem_wr, io_rd, io_wr, tc, mark
   );
endinterface

// File: rtl/k580vt57_prio.sv
// Purpose : channel priority encoder with fixed or rotating priority.
// Latency : grant combinational from req; rotate pointer updates one clk after adv.
// Backpressure : none; caller pulses adv when it accepts the grant.
// Ports : req = eligible mask, rotate = rotating mode, adv = grant taken, grant = one-hot winner.
module k580vt57_prio #(
   parameter int CH = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          rotate,
   input  logic          adv,
   input  logic [CH-1:0] req,
   output logic [CH-1:0] grant
);
   localparam int W = $clog2(CH);

   logic [W-1:0] ptr;   // channel currently holding top priority
   logic [W-1:0] base;
   logic [W-1:0] idx;
   logic [W-1:0] gidx;

   // Scan from lowest to highest priority so the last hit wins.
   // The W-bit add wraps modulo CH because CH is a power of two.
   always_comb begin
      base  = rotate ? ptr : '0;
      grant = '0;
      gidx  = '0;
      idx   = '0;
      for (int i = CH - 1; i >= 0; i--) begin
         idx = base + W'(i);
         if (req[idx]) begin
            grant      = '0;
            grant[idx] = 1'b1;
            gidx       = idx;
         end
      end
   end

   // The channel just serviced becomes lowest: next one up becomes highest.
   always_ff @(posedge clk) begin
      if (reset)
         ptr <= '0;
      else if (adv)
         ptr <= gidx + 1'b1;
   end

endmodule

// File: rtl/k580vt57.sv
// Purpose : four-channel DMA controller (k580vt57): CPU register file, arbitration, HRQ/HLDA, one byte per transfer.
// Latency : hrq one ce_dma step after drq sampled; transfer S0->S1->S2->S3 = 4 steps after hlda, +3 per burst byte.
// Backpressure : waits in S0 for hlda; burst continues only while drq, enable and hlda all stay high.
// Ports : clk, reset (sync, active-high), ce_dma (state advance enable), bus (k580vt57_if.slave).
module k580vt57
   import k580vt57_pkg::*;
#(
   parameter int CH = 4
) (
   input logic         clk,
   input logic         reset,
   input logic         ce_dma,
   k580vt57_if.slave   bus
);
   localparam int CW = $clog2(CH);

   state_t        state, state_nx;
   logic [15:0]   ch_addr [CH];
   logic [15:0]   ch_cnt  [CH];
   logic [CH-1:0] en;
   logic          rot, stop, autold;
   logic [CH-1:0] tc_flag;
   logic          upd_flag;
   logic          ff;           // byte flip-flop: 0 = low byte next
   logic          iwe_q, ird_q;
   logic          hlda_lost;    // hlda dropped mid-transfer: finish, then release bus
   logic [CW-1:0] cur;
   logic [CH-1:0] req_q;
   logic [CH-1:0] grant;
   logic [CW-1:0] gidx;

   logic          we_rise, rd_rise, acc_ch;
   logic [CW-1:0] rch;
   logic [15:0]   sel_val;
   logic [1:0]    typ;
   logic          tc_now, reload, en_after, burst;

   assign we_rise  = bus.iwe_n & ~iwe_q;
   assign rd_rise  = bus.ird_n & ~ird_q;
   assign acc_ch   = ~bus.iaddr[3];
   assign rch      = bus.iaddr[2:1];
   assign typ      = ch_cnt[cur][15:14];
   assign tc_now   = (ch_cnt[cur][13:0] == 14'd0);
   assign reload   = tc_now & autold & (cur == 2'd2);
   // Autoload keeps channel 2 running, so stop-on-TC does not apply to it then.
   assign en_after = en[cur] & ~(tc_now & stop & ~reload);
   assign burst    = bus.drq[cur] & en_after & bus.hlda & ~hlda_lost;

   k580vt57_prio #(.CH(CH)) u_prio (
      .clk    (clk),
      .reset  (reset),
      .rotate (rot),
      .adv    (ce_dma && state == ST_S0 && bus.hlda),
      .req    (req_q),
      .grant  (grant)
   );

   always_comb begin
      gidx = '0;
      for (int i = 0; i < CH; i++)
         if (grant[i]) gidx = CW'(i);
   end

   // ---- FSM: state register ----
   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nx;
   end

   // ---- FSM: next state ----
   always_comb begin
      state_nx = state;
      if (ce_dma) begin
         case (state)
            ST_IDLE: if (|(bus.drq & en)) state_nx = ST_S0;
            ST_S0:   if (bus.hlda)        state_nx = ST_S1;
            ST_S1:   state_nx = ST_S2;
            ST_S2:   state_nx = ST_S3;
            ST_S3:   state_nx = burst ? ST_S1 : ST_IDLE;
            default: state_nx = ST_IDLE;
         endcase
      end
   end

   // ---- FSM: outputs ----
   always_comb begin
      bus.hrq    = (state != ST_IDLE);
      bus.dack   = '0;
      bus.oaddr  = '0;
      bus.tc     = 1'b0;
      bus.mark   = 1'b0;
      bus.mem_rd = 1'b0;
      bus.mem_wr = 1'b0;
      bus.io_rd  = 1'b0;
      bus.io_wr  = 1'b0;
      if (state == ST_S1 || state == ST_S2 || state == ST_S3) begin
         bus.dack[cur] = 1'b1;
         bus.oaddr     = ch_addr[cur];
         bus.tc        = tc_now;
         bus.mark      = (ch_cnt[cur][6:0] == 7'd0);
         if (state == ST_S2) begin
            case (typ)
               TYP_WRITE: begin bus.io_rd  = 1'b1; bus.mem_wr = 1'b1; end
               TYP_READ:  begin bus.mem_rd = 1'b1; bus.io_wr  = 1'b1; end
               default:   ;
            endcase
         end
      end
   end

   // CPU read data, combinational from iaddr.
   always_comb begin
      sel_val   = bus.iaddr[0] ? ch_cnt[rch] : ch_addr[rch];
      bus.odata = 8'h00;
      if (acc_ch)
         bus.odata = ff ? sel_val[15:8] : sel_val[7:0];
      else if (bus.iaddr == REG_MODE)
         bus.odata = {3'b000, upd_flag, tc_flag};
   end

   // Register file. CPU accesses come last so they override the S3 update.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < CH; i++) begin
            ch_addr[i] <= '0;
            ch_cnt[i]  <= '0;
         end
         en        <= '0;
         rot       <= 1'b0;
         stop      <= 1'b0;
         autold    <= 1'b0;
         tc_flag   <= '0;
         upd_flag  <= 1'b0;
         ff        <= 1'b0;
         iwe_q     <= 1'b1;   // idle level of the strobe, so no edge right after reset
         ird_q     <= 1'b1;
         cur       <= '0;
         req_q     <= '0;
         hlda_lost <= 1'b0;
      end else begin
         iwe_q <= bus.iwe_n;
         ird_q <= bus.ird_n;

         if (state == ST_IDLE)
            hlda_lost <= 1'b0;
         else if ((state == ST_S1 || state == ST_S2) && !bus.hlda)
            hlda_lost <= 1'b1;

         if (ce_dma) begin
            case (state)
               ST_IDLE: req_q <= bus.drq & en;   // drq may drop in S0; request still served
               ST_S0:   if (bus.hlda) cur <= gidx;
               ST_S3: begin
                  ch_addr[cur] <= ch_addr[cur] + 16'd1;
                  ch_cnt[cur]  <= {ch_cnt[cur][15:14], ch_cnt[cur][13:0] - 14'd1};
                  if (tc_now) tc_flag[cur] <= 1'b1;
                  if (tc_now && stop && !reload) en[cur] <= 1'b0;
                  if (reload) begin
                     ch_addr[2'd2] <= ch_addr[2'd3];
                     ch_cnt[2'd2]  <= ch_cnt[2'd3];
                     upd_flag      <= 1'b1;
                  end else begin
                     upd_flag <= 1'b0;
                  end
               end
               default: ;
            endcase
         end

         if (we_rise) begin
            if (acc_ch) begin
               if (bus.iaddr[0]) begin
                  ch_cnt[rch] <= put_byte(ch_cnt[rch], ff, bus.idata);
                  if (autold && rch == 2'd2)
                     ch_cnt[2'd3] <= put_byte(ch_cnt[2'd3], ff, bus.idata);
               end else begin
                  ch_addr[rch] <= put_byte(ch_addr[rch], ff, bus.idata);
                  if (autold && rch == 2'd2)
                     ch_addr[2'd3] <= put_byte(ch_addr[2'd3], ff, bus.idata);
               end
               ff <= ~ff;
            end else if (bus.iaddr == REG_MODE) begin
               en     <= bus.idata[CH-1:0];
               rot    <= bus.idata[MODE_ROT];
               stop   <= bus.idata[MODE_STOP];
               autold <= bus.idata[MODE_AUTO];
               ff     <= 1'b0;
            end
         end else if (rd_rise) begin
            if (acc_ch)
               ff <= ~ff;
            else if (bus.iaddr == REG_MODE)
               tc_flag <= '0;
         end
      end
   end

endmodule

// File: tb/tb_k580vt57.sv
// Purpose : self-checking bench for k580vt57: register-map vector table plus scoreboarded DMA transfer sequences.
// Latency : n/a.
// Backpressure : hlda driven by the bench; every wait on the DUT is bounded.
module tb_k580vt57;
   import k580vt57_pkg::*;

   logic clk;
   logic reset;
   logic ce_dma;

   k580vt57_if #(.CH(4)) dif ();

   k580vt57 #(.CH(4)) dut (
      .clk    (clk),
      .reset  (reset),
      .ce_dma (ce_dma),
      .bus    (dif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   typedef struct packed {
      logic [1:0]  ch;
      logic [15:0] addr;
      logic        tc;
      logic        mark;
      logic [1:0]  typ;
   } xfer_t;

   typedef struct {
      logic       wr;
      logic [3:0] a;
      logic [7:0] d;
      logic [7:0] exp;
   } reg_vec_t;

   xfer_t    sb[$];
   reg_vec_t tbl[21];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // Each strobe pulse (S2) is one transfer; compare it against the oldest expectation.
   always @(negedge clk) begin : mon
      xfer_t      e;
      logic [3:0] exp_dack;
      logic [3:0] exp_strb;
      if (!reset && (dif.mem_rd || dif.mem_wr || dif.io_rd || dif.io_wr)) begin
         chk("xfer_expected", sb.size() != 0, 1);
         if (sb.size() != 0) begin
            e        = sb.pop_front();
            exp_dack = 4'b0001 << e.ch;
            exp_strb = (e.typ == TYP_WRITE) ? 4'b0110 : 4'b1001;
            chk("xfer_dack", dif.dack, exp_dack);
            chk("xfer_oaddr", dif.oaddr, e.addr);
            chk("xfer_tc", dif.tc, e.tc);
            chk("xfer_mark", dif.mark, e.mark);
            chk("xfer_strobes", {dif.mem_rd, dif.mem_wr, dif.io_rd, dif.io_wr}, exp_strb);
         end
      end
   end

   task automatic cpu_wr(input logic [3:0] a, input logic [7:0] d);
      @(negedge clk);
      dif.iaddr = a; dif.idata = d; dif.iwe_n = 1'b0;
      @(negedge clk);
      dif.iwe_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic cpu_rd(input logic [3:0] a, output logic [7:0] d);
      @(negedge clk);
      dif.iaddr = a; dif.ird_n = 1'b0;
      @(negedge clk);
      d = dif.odata;
      dif.ird_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic rd_chk(input string nm, input logic [3:0] a, input logic [7:0] exp);
      logic [7:0] d;
      cpu_rd(a, d);
      chk(nm, d, exp);
   endtask

   task automatic do_reset();
      dif.drq = '0; dif.iwe_n = 1'b1; dif.ird_n = 1'b1; dif.hlda = 1'b1; ce_dma = 1'b1;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic wait_drain(input string nm, input int budget);
      int t = 0;
      while (sb.size() != 0 && t < budget) begin @(negedge clk); t++; end
      chk(nm, sb.size(), 0);
   endtask

   task automatic wait_idle(input string nm, input int budget);
      int t = 0;
      while (dif.hrq !== 1'b0 && t < budget) begin @(negedge clk); t++; end
      chk(nm, dif.hrq, 0);
   endtask

   task automatic push(input logic [1:0] ch, input logic [15:0] a, input logic [13:0] n, input logic [1:0] typ);
      xfer_t e;
      e.ch = ch; e.addr = a; e.tc = (n == 14'd0); e.mark = (n[6:0] == 7'd0); e.typ = typ;
      sb.push_back(e);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int t;
      logic [3:0] dq;

      dif.iaddr = '0; dif.idata = '0;
      tbl[0]  = '{1'b0, 4'h0, 8'h00, 8'h00};
      tbl[1]  = '{1'b0, 4'h0, 8'h00, 8'h00};
      tbl[2]  = '{1'b1, 4'h0, 8'h34, 8'h00};
      tbl[3]  = '{1'b1, 4'h0, 8'h9A, 8'h00};
      tbl[4]  = '{1'b0, 4'h0, 8'h00, 8'h34};
      tbl[5]  = '{1'b0, 4'h0, 8'h00, 8'h9A};
      tbl[6]  = '{1'b1, 4'h3, 8'hAB, 8'h00};
      tbl[7]  = '{1'b1, 4'h3, 8'hCD, 8'h00};
      tbl[8]  = '{1'b0, 4'h3, 8'h00, 8'hAB};
      tbl[9]  = '{1'b0, 4'h3, 8'h00, 8'hCD};
      tbl[10] = '{1'b0, 4'hF, 8'h00, 8'h00};
      tbl[11] = '{1'b0, 4'h8, 8'h00, 8'h00};
      tbl[12] = '{1'b1, 4'h0, 8'h56, 8'h00};
      tbl[13] = '{1'b1, 4'h8, 8'h00, 8'h00};
      tbl[14] = '{1'b1, 4'h0, 8'h12, 8'h00};
      tbl[15] = '{1'b1, 4'h8, 8'h00, 8'h00};
      tbl[16] = '{1'b0, 4'h0, 8'h00, 8'h12};
      tbl[17] = '{1'b0, 4'h0, 8'h00, 8'h9A};
      tbl[18] = '{1'b1, 4'h9, 8'h77, 8'h00};
      tbl[19] = '{1'b0, 4'h0, 8'h00, 8'h12};
      tbl[20] = '{1'b0, 4'h0, 8'h00, 8'h9A};

      // ---- reset state ----
      do_reset();
      dif.iaddr = REG_MODE;
      @(negedge clk);
      chk("rst_hrq", dif.hrq, 0);
      chk("rst_dack", dif.dack, 0);
      chk("rst_oaddr", dif.oaddr, 0);
      chk("rst_strobes", {dif.mem_rd, dif.mem_wr, dif.io_rd, dif.io_wr, dif.tc, dif.mark}, 0);
      chk("rst_odata", dif.odata, 0);

      // ---- register map / byte flip-flop table ----
      for (int i = 0; i < 21; i++) begin
         if (tbl[i].wr) cpu_wr(tbl[i].a, tbl[i].d);
         else           rd_chk($sformatf("reg_tbl[%0d]", i), tbl[i].a, tbl[i].exp);
      end

      // ---- ce_dma gating, hrq timing, drq dropped in S0 ----
      do_reset();
      ce_dma = 1'b0; dif.hlda = 1'b0;
      cpu_wr(4'h8, 8'h01);
      cpu_wr(4'h0, 8'h55); cpu_wr(4'h0, 8'h00);
      cpu_wr(4'h1, 8'h00); cpu_wr(4'h1, 8'h40);
      dif.drq = 4'h1;
      repeat (5) @(negedge clk);
      chk("ce_gate_hrq", dif.hrq, 0);
      ce_dma = 1'b1;
      @(negedge clk);
      chk("hrq_one_step", dif.hrq, 1);
      dif.drq = 4'h0;
      repeat (4) @(negedge clk);
      chk("s0_hold_hrq", dif.hrq, 1);
      push(2'd0, 16'h0055, 14'd0, TYP_WRITE);
      dif.hlda = 1'b1;
      wait_drain("s0_drain", 20);
      wait_idle("s0_idle", 20);

      // ---- stop on TC: mode 0x41, ch0 count 0x4002 ----
      do_reset();
      cpu_wr(4'h8, 8'h41);
      cpu_wr(4'h0, 8'h00); cpu_wr(4'h0, 8'h01);
      cpu_wr(4'h1, 8'h02); cpu_wr(4'h1, 8'h40);
      for (int k = 0; k < 3; k++) push(2'd0, 16'h0100 + 16'(k), 14'(2 - k), TYP_WRITE);
      dif.drq = 4'h1;
      wait_drain("stop_drain", 100);
      repeat (10) @(negedge clk);
      chk("stop_no_more_hrq", dif.hrq, 0);
      dif.drq = 4'h0;
      rd_chk("stop_status", 4'h8, 8'h01);
      rd_chk("stop_status_clr", 4'h8, 8'h00);

      // ---- rotating priority, single transfers ----
      do_reset();
      for (int c = 0; c < 4; c++) begin
         cpu_wr(4'(2 * c + 1), 8'h00); cpu_wr(4'(2 * c + 1), 8'h40);
      end
      cpu_wr(4'h8, 8'h1F);
      for (int c = 0; c < 4; c++) push(2'(c), 16'h0000, 14'd0, TYP_WRITE);
      push(2'd0, 16'h0001, 14'h3FFF, TYP_WRITE);
      for (int k = 0; k < 5; k++) begin
         dif.drq = 4'hF;
         t = 0;
         while (dif.dack == 4'h0 && t < 50) begin @(negedge clk); t++; end
         chk("rot_dack_seen", t < 50, 1);
         dq = dif.dack;
         dif.drq = 4'hF & ~dq;
         t = 0;
         while (dif.dack != 4'h0 && t < 50) begin @(negedge clk); t++; end
         chk("rot_dack_release", t < 50, 1);
      end
      dif.drq = 4'h0;
      wait_drain("rot_drain", 50);
      wait_idle("rot_idle", 20);

      // ---- fixed priority, drq = 0x6 ----
      do_reset();
      cpu_wr(4'h8, 8'h46);
      cpu_wr(4'h2, 8'h00); cpu_wr(4'h2, 8'h10);
      cpu_wr(4'h3, 8'h01); cpu_wr(4'h3, 8'h80);
      cpu_wr(4'h4, 8'h00); cpu_wr(4'h4, 8'h20);
      cpu_wr(4'h5, 8'h00); cpu_wr(4'h5, 8'h80);
      push(2'd1, 16'h1000, 14'd1, TYP_READ);
      push(2'd1, 16'h1001, 14'd0, TYP_READ);
      push(2'd2, 16'h2000, 14'd0, TYP_READ);
      dif.drq = 4'h6;
      wait_drain("fix_drain", 200);
      repeat (10) @(negedge clk);
      chk("fix_idle_hrq", dif.hrq, 0);
      dif.drq = 4'h0;
      rd_chk("fix_status", 4'h8, 8'h06);

      // ---- long autoload burst on ch2 ----
      do_reset();
      cpu_wr(4'h8, 8'hA4);
      cpu_wr(4'h4, 8'hD0); cpu_wr(4'h4, 8'h76);
      cpu_wr(4'h5, 8'h9F); cpu_wr(4'h5, 8'h8F);
      for (int k = 0; k < 16'h0FA0; k++) push(2'd2, 16'h76D0 + 16'(k), 14'(16'h0F9F - k), TYP_READ);
      dif.drq = 4'h4;
      t = 0;
      while (!(dif.tc && dif.dack[2]) && t < 15000) begin @(negedge clk); t++; end
      chk("auto_tc_seen", t < 15000, 1);
      chk("auto_last_oaddr", dif.oaddr, 16'h866F);
      dif.drq = 4'h0;
      wait_drain("auto_drain", 20);
      wait_idle("auto_idle", 20);
      rd_chk("auto_ch2_addr_lo", 4'h4, 8'hD0);
      rd_chk("auto_ch2_addr_hi", 4'h4, 8'h76);
      rd_chk("auto_ch2_cnt_lo", 4'h5, 8'h9F);
      rd_chk("auto_ch2_cnt_hi", 4'h5, 8'h8F);
      rd_chk("auto_ch3_addr_lo", 4'h6, 8'hD0);
      rd_chk("auto_ch3_addr_hi", 4'h6, 8'h76);
      rd_chk("auto_status", 4'h8, 8'h14);
      rd_chk("auto_status_upd", 4'h8, 8'h10);

      // ---- reset asserted mid-S2 ----
      do_reset();
      cpu_wr(4'h8, 8'h01);
      cpu_wr(4'h0, 8'h00); cpu_wr(4'h0, 8'h03);
      cpu_wr(4'h1, 8'h05); cpu_wr(4'h1, 8'h40);
      push(2'd0, 16'h0300, 14'd5, TYP_WRITE);
      dif.drq = 4'h1;
      t = 0;
      while (!dif.mem_wr && t < 50) begin @(negedge clk); t++; end
      chk("rs2_reached", t < 50, 1);
      #1 reset = 1'b1;
      @(negedge clk);
      chk("rs2_strobes", {dif.mem_rd, dif.mem_wr, dif.io_rd, dif.io_wr}, 0);
      chk("rs2_hrq", dif.hrq, 0);
      chk("rs2_dack", dif.dack, 0);
      dif.drq = 4'h0;
      reset = 1'b0;
      rd_chk("rs2_addr_lo", 4'h0, 8'h00);
      rd_chk("rs2_addr_hi", 4'h0, 8'h00);
      rd_chk("rs2_cnt_lo", 4'h1, 8'h00);
      chk("rs2_sb_drained", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
